// File: rtl/dmem_stage_pkg.sv
// Shared RISC-V types for the memory stage: decoded operations, destination port,
// fault causes, FSM states and load/store classification helpers.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW
  } operation_e;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic            valid;
  } rd_port_t;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_RANGE    = 2'd2
  } mem_fault_e;

  typedef enum logic {IDLE, WAIT} dmem_state_e;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_e;

  function automatic logic is_load(operation_e op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(operation_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic mem_size_e access_size(operation_e op);
    if (op inside {OP_LB, OP_LBU, OP_SB}) return SZ_BYTE;
    if (op inside {OP_LH, OP_LHU, OP_SH}) return SZ_HALF;
    return SZ_WORD;
  endfunction

  function automatic logic is_unsigned_load(operation_e op);
    return op inside {OP_LBU, OP_LHU};
  endfunction

endpackage

// File: rtl/dmem_stage_if.sv
// Execute-side request and writeback-side result bundle of the memory stage.
interface dmem_stage_if;
  import riscv_pkg::*;

  logic                 valid_i;
  logic [XLEN-1:0]      pc_i;
  logic [XLEN-1:0]      instr_i;
  operation_e           operation_i;
  rd_port_t             rd_port_i;
  logic [XLEN-1:0]      addr_i;
  logic [XLEN-1:0]      wdata_i;
  logic                 stall_o;
  logic                 valid_o;
  logic [XLEN-1:0]      pc_o;
  logic [XLEN-1:0]      instr_o;
  rd_port_t             rd_port_o;
  mem_fault_e           fault_o;
  logic [XLEN-1:0]      bad_addr_o;

  modport slave (
    input  valid_i, pc_i, instr_i, operation_i, rd_port_i, addr_i, wdata_i,
    output stall_o, valid_o, pc_o, instr_o, rd_port_o, fault_o, bad_addr_o
  );

  modport master (
    output valid_i, pc_i, instr_i, operation_i, rd_port_i, addr_i, wdata_i,
    input  stall_o, valid_o, pc_o, instr_o, rd_port_o, fault_o, bad_addr_o
  );

endinterface

// File: rtl/dmem_stage_bank.sv
// Word-organised data RAM: asynchronous read, byte-strobed synchronous write, no reset.
module dmem_bank #(
  parameter int unsigned MEM_WORDS = 2048,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_stage.sv
// MEM->WB pipeline stage: byte-lane loads/stores with wait states, alignment and
// range faulting, and an upstream stall while an access is pending.
module dmem_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_WORDS   = 2048,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dmem_stage_if.slave  bus
);
  import riscv_pkg::*;

  localparam int unsigned AW      = $clog2(MEM_WORDS);
  localparam logic [2:0]  WaitMax = 3'(WAIT_CYCLES);

  dmem_state_e     state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;

  logic            ld, st, mem_op, good_mem;
  logic            misalign, out_of_range, stall, complete, accept;
  mem_size_e       size;
  mem_fault_e      fault;
  logic [1:0]      lane;
  logic [3:0]      be;
  logic [31:0]     wdata_lanes, rdata, shifted, load_val;
  rd_port_t        rd_d;

  logic            valid_q;
  logic [XLEN-1:0] pc_q, instr_q, bad_addr_q;
  rd_port_t        rd_q;
  mem_fault_e      fault_q;

  // Request classification and fault detection
  always_comb begin
    ld           = is_load(bus.operation_i);
    st           = is_store(bus.operation_i);
    mem_op       = bus.valid_i && (ld || st);
    size         = access_size(bus.operation_i);
    misalign     = CHECK_ALIGN && ((size == SZ_HALF && bus.addr_i[0]) ||
                                   (size == SZ_WORD && bus.addr_i[1:0] != 2'b00));
    out_of_range = ({2'b00, bus.addr_i[XLEN-1:2]} >= XLEN'(MEM_WORDS));
    fault        = FLT_NONE;
    if (mem_op) begin
      if (misalign)          fault = FLT_MISALIGN;
      else if (out_of_range) fault = FLT_RANGE;
    end
    good_mem = mem_op && (fault == FLT_NONE);
    lane     = (!CHECK_ALIGN && size != SZ_BYTE) ? 2'b00 : bus.addr_i[1:0];
  end

  // Wait-state sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (good_mem) begin
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = WAIT;
            cnt_d   = 3'd1;
          end
        end
      end
      WAIT: begin
        if (!good_mem) begin
          // Request withdrawn mid-access: abandon it without writing
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q < WaitMax) begin
          stall = 1'b1;
          cnt_d = cnt_q + 3'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Store lane steering: data is replicated so every enabled lane sees its byte
  always_comb begin
    be          = 4'b0000;
    wdata_lanes = bus.wdata_i[31:0];
    case (size)
      SZ_BYTE: begin
        be          = 4'b0001 << lane;
        wdata_lanes = {4{bus.wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be          = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{bus.wdata_i[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  dmem_bank #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_bank (
    .clk_i   (clk_i),
    .we_i    (complete && st),
    .be_i    (be),
    .addr_i  (bus.addr_i[AW+1:2]),
    .wdata_i (wdata_lanes),
    .rdata_o (rdata)
  );

  // Load extraction and extension
  always_comb begin
    shifted  = rdata >> {lane, 3'b000};
    load_val = rdata;
    case (size)
      SZ_BYTE: load_val = is_unsigned_load(bus.operation_i) ? {24'h0, shifted[7:0]}
                                                            : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = is_unsigned_load(bus.operation_i) ? {16'h0, shifted[15:0]}
                                                            : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = rdata;
    endcase
  end

  always_comb begin
    rd_d = bus.rd_port_i;
    if (fault != FLT_NONE)  rd_d.valid = 1'b0;
    else if (mem_op && ld)  rd_d.data  = load_val;
  end

  assign accept = bus.valid_i && !stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
      rd_q       <= '0;
      fault_q    <= FLT_NONE;
      bad_addr_q <= '0;
    end else begin
      valid_q    <= accept;
      fault_q    <= FLT_NONE;
      bad_addr_q <= '0;
      if (accept) begin
        pc_q    <= bus.pc_i;
        instr_q <= bus.instr_i;
        rd_q    <= rd_d;
        if (fault != FLT_NONE) begin
          fault_q    <= fault;
          bad_addr_q <= bus.addr_i;
        end
      end
    end
  end

  assign bus.stall_o    = stall;
  assign bus.valid_o    = valid_q;
  assign bus.pc_o       = pc_q;
  assign bus.instr_o    = instr_q;
  assign bus.rd_port_o  = rd_q;
  assign bus.fault_o    = fault_q;
  assign bus.bad_addr_o = bad_addr_q;

endmodule

// File: tb/tb_dmem_stage.sv
// Scoreboarded random/directed bench for dmem_stage against a byte-array memory model.
module tb_dmem_stage;
  import riscv_pkg::*;

  localparam int unsigned MemWords   = 2048;
  localparam int unsigned WaitCycles = 2;
  localparam int unsigned Region     = 256;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    rd_port_t    rd;
    mem_fault_e  fault;
    logic [31:0] bad;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb [$];
  exp_t mon_e;
  logic [7:0] model [MemWords*4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_stage_if bus ();

  dmem_stage #(
    .XLEN        (32),
    .MEM_WORDS   (MemWords),
    .WAIT_CYCLES (WaitCycles),
    .CHECK_ALIGN (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Access size in bytes; 0 means not a memory operation
  function automatic int ref_size(operation_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(operation_e op, logic [31:0] a);
    logic [15:0] h;
    h = {model[a+1], model[a]};
    case (op)
      OP_LB:   return {{24{model[a][7]}}, model[a]};
      OP_LBU:  return {24'h0, model[a]};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return {model[a+3], model[a+2], model[a+1], model[a]};
    endcase
  endfunction

  task automatic issue(input operation_e op, input logic [31:0] addr,
                       input logic [31:0] wdata, input rd_port_t rd);
    exp_t       e;
    int         n;
    int         exp_n;
    int         sz;
    mem_fault_e f;
    bus.valid_i     = 1'b1;
    bus.operation_i = op;
    bus.addr_i      = addr;
    bus.wdata_i     = wdata;
    bus.rd_port_i   = rd;
    bus.pc_i        = $urandom;
    bus.instr_i     = $urandom;
    sz = ref_size(op);
    f  = FLT_NONE;
    if (sz != 0) begin
      if (addr % sz != 0)               f = FLT_MISALIGN;
      else if ((addr / 4) >= MemWords)  f = FLT_RANGE;
    end
    exp_n   = (sz != 0 && f == FLT_NONE) ? WaitCycles : 0;
    e.pc    = bus.pc_i;
    e.instr = bus.instr_i;
    e.rd    = rd;
    e.fault = f;
    e.bad   = (f != FLT_NONE) ? addr : 32'h0;
    e.cyc   = cyc + exp_n + 1;
    if (f != FLT_NONE) begin
      e.rd.valid = 1'b0;
    end else if (op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU}) begin
      e.rd.data = ref_load(op, addr);
    end else if (sz != 0) begin
      for (int i = 0; i < sz; i++) model[addr+i] = wdata[8*i +: 8];
    end
    n = 0;
    @(negedge clk);
    while (bus.stall_o !== 1'b0 && n < 16) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", 32'(n), 32'(exp_n));
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  function automatic rd_port_t mk_rd(logic [31:0] data);
    rd_port_t r;
    r.addr  = 5'($urandom_range(1, 31));
    r.data  = data;
    r.valid = 1'b1;
    return r;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},    32'(bus.valid_o), 32'h0);
    chk({tag, "_pc"},       bus.pc_o, 32'h0);
    chk({tag, "_instr"},    bus.instr_o, 32'h0);
    chk({tag, "_rd_data"},  bus.rd_port_o.data, 32'h0);
    chk({tag, "_rd_meta"},  {26'h0, bus.rd_port_o.addr, bus.rd_port_o.valid}, 32'h0);
    chk({tag, "_fault"},    32'(bus.fault_o), 32'(FLT_NONE));
    chk({tag, "_bad_addr"}, bus.bad_addr_o, 32'h0);
  endtask

  // Monitor: every valid_o must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got valid_o=1 pc=%h expected no result", bus.pc_o);
      end else begin
        mon_e = sb.pop_front();
        chk("pc",       bus.pc_o, mon_e.pc);
        chk("instr",    bus.instr_o, mon_e.instr);
        chk("rd_data",  bus.rd_port_o.data, mon_e.rd.data);
        chk("rd_addr",  32'(bus.rd_port_o.addr), 32'(mon_e.rd.addr));
        chk("rd_valid", 32'(bus.rd_port_o.valid), 32'(mon_e.rd.valid));
        chk("fault",    32'(bus.fault_o), 32'(mon_e.fault));
        chk("bad_addr", bus.bad_addr_o, mon_e.bad);
        chk("latency",  32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  operation_e ops [14] = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LB, OP_LH,
                           OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

  initial begin
    logic [31:0] a;
    int          k;
    rst             = 1'b1;
    bus.valid_i     = 1'b0;
    bus.operation_i = OP_NOP;
    bus.addr_i      = '0;
    bus.wdata_i     = '0;
    bus.rd_port_i   = '0;
    bus.pc_i        = '0;
    bus.instr_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Give every word of the test region a known value
    for (int w = 0; w < int'(Region / 4); w++) issue(OP_SW, 32'(w * 4), $urandom, mk_rd(0));

    issue(OP_SW,  32'h10, 32'hDEADBEEF, mk_rd(32'h1));
    issue(OP_LW,  32'h10, 32'h0, mk_rd(32'h0));
    issue(OP_LB,  32'h13, 32'h0, mk_rd(32'h0));
    issue(OP_LBU, 32'h13, 32'h0, mk_rd(32'h0));
    issue(OP_LH,  32'h12, 32'h0, mk_rd(32'h0));
    issue(OP_LHU, 32'h10, 32'h0, mk_rd(32'h0));
    issue(OP_SW,  32'h20, 32'h0, mk_rd(32'h0));
    issue(OP_SB,  32'h21, 32'h5A, mk_rd(32'h0));
    issue(OP_LW,  32'h20, 32'h0, mk_rd(32'h0));
    issue(OP_SH,  32'h22, 32'h1234, mk_rd(32'h0));
    issue(OP_LW,  32'h20, 32'h0, mk_rd(32'h0));
    issue(OP_LW,  32'h102, 32'h0, mk_rd(32'h0));
    issue(OP_LW,  32'(MemWords * 4), 32'h0, mk_rd(32'h0));
    issue(OP_ADD, 32'h0, 32'h0, mk_rd(32'h7));

    // Store interrupted by reset while waiting must not reach memory
    issue(OP_SW, 32'h40, 32'hCAFEF00D, mk_rd(32'h0));
    repeat (2) @(negedge clk);
    bus.valid_i     = 1'b1;
    bus.operation_i = OP_SW;
    bus.addr_i      = 32'h40;
    bus.wdata_i     = 32'h11111111;
    @(negedge clk);
    chk("stall_before_reset", 32'(bus.stall_o), 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    bus.valid_i = 1'b0;
    #1;
    chk_reset_outputs("midwait");
    chk("stall_after_reset", 32'(bus.stall_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(OP_LW, 32'h40, 32'h0, mk_rd(32'h0));

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 99);
      if (k < 85)      a = 32'($urandom_range(0, Region - 1));
      else if (k < 95) a = 32'(MemWords * 4) + 32'($urandom_range(0, 1023));
      else             a = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(ops[$urandom_range(0, 13)], a, $urandom, mk_rd($urandom));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
